// File: rtl/note_lane_sequencer.sv
// rtl/note_lane_sequencer.sv - falling-object spawn, motion, hit judging, score and game state
// Optional SPEEDUP_EN: step divisor shrinks by 1/8 after every 8th hit, floored at SPEED_DIV/4.
module note_lane_sequencer #(
   parameter int NSLOT     = 4,
   parameter int SPEED_DIV = 500000,
   parameter int SPAWN_GAP = 60,
   parameter int ZONE_TOP  = 400,
   parameter int ZONE_BOT  = 475,
   parameter int MAX_MISS  = 3
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic                button,
   output logic [10*NSLOT-1:0] obj_y,
   output logic [NSLOT-1:0]    obj_active,
   output logic [15:0]         score,
   output logic [3:0]          misses,
   output logic [1:0]          state,
   output logic                hit_pulse,
   output logic                miss_pulse
);

   localparam int DW = $clog2(SPEED_DIV + 1);
   localparam int SW = $clog2(SPAWN_GAP + 1);
   localparam int MW = $clog2(NSLOT + 16) + 1;

   localparam logic [DW-1:0] L_DIV     = DW'(SPEED_DIV);
   localparam logic [SW-1:0] L_GAP     = SW'(SPAWN_GAP);
   localparam logic [SW-1:0] L_GAP_M1  = SW'(SPAWN_GAP - 1);
   localparam logic [9:0]    L_ZT      = 10'(ZONE_TOP);
   localparam logic [9:0]    L_ZB      = 10'(ZONE_BOT);
   localparam logic [3:0]    L_MAXM    = 4'(MAX_MISS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_OVER = 2'd2
   } state_t;

   state_t           r_state, w_state_nxt;
   logic             r_start_q, r_button_q;
   logic [9:0]       r_y [NSLOT];
   logic [9:0]       w_y_nxt [NSLOT];
   logic [NSLOT-1:0] r_active, w_active_nxt;
   logic [15:0]      r_score, w_score_nxt;
   logic [3:0]       r_misses, w_misses_nxt;
   logic [DW-1:0]    r_step_cnt, w_step_nxt;
   logic [SW-1:0]    r_spawn_cnt, w_spawn_nxt;
   logic             r_hit_pulse, w_hit_nxt;
   logic             r_miss_pulse, w_miss_nxt;

   logic             w_press, w_go, w_step, w_spawn_due;
   logic [DW-1:0]    w_div;
   logic [NSLOT-1:0] w_zone, w_hit_sel, w_free, w_spawn_sel;
   logic [MW-1:0]    w_miss_cnt, w_miss_sum;

`ifdef SPEEDUP_EN
   localparam logic [DW-1:0] L_DIV_MIN = DW'(SPEED_DIV / 4);
   logic [DW-1:0]    r_cur_div, w_div_nxt, w_shrunk;
   assign w_div    = r_cur_div;
   assign w_shrunk = r_cur_div - (r_cur_div >> 3);
`else
   assign w_div    = L_DIV;
`endif

   assign w_press     = button & ~r_button_q;
   assign w_go        = start & ~r_start_q;
   assign w_step      = (r_state == S_PLAY) && (r_step_cnt >= w_div - DW'(1));
   assign w_spawn_due = w_step && (r_spawn_cnt >= L_GAP_M1);

   always_comb begin
      w_zone = '0;
      for (int i = 0; i < NSLOT; i++) begin
         w_zone[i] = r_active[i] && (r_y[i] >= L_ZT) && (r_y[i] <= L_ZB);
      end
   end

   // Lowest-set-bit pick; the free mask is pre-update, so a slot freed this cycle is never reused.
   assign w_hit_sel   = w_press ? (w_zone & (~w_zone + NSLOT'(1))) : '0;
   assign w_free      = ~r_active;
   assign w_spawn_sel = w_spawn_due ? (w_free & (~w_free + NSLOT'(1))) : '0;

   always_comb begin
      w_state_nxt  = r_state;
      w_y_nxt      = r_y;
      w_active_nxt = r_active;
      w_score_nxt  = r_score;
      w_misses_nxt = r_misses;
      w_step_nxt   = r_step_cnt;
      w_spawn_nxt  = r_spawn_cnt;
      w_hit_nxt    = 1'b0;
      w_miss_nxt   = 1'b0;
      w_miss_cnt   = '0;
      w_miss_sum   = '0;
`ifdef SPEEDUP_EN
      w_div_nxt    = r_cur_div;
`endif
      if (w_go) begin
         w_y_nxt      = '{default: '0};
         w_active_nxt = '0;
         w_score_nxt  = '0;
         w_misses_nxt = '0;
         w_step_nxt   = '0;
         w_spawn_nxt  = '0;
`ifdef SPEEDUP_EN
         w_div_nxt    = L_DIV;
`endif
      end else if (r_state == S_PLAY) begin
         w_step_nxt = w_step ? '0 : r_step_cnt + DW'(1);
         for (int i = 0; i < NSLOT; i++) begin
            if (w_hit_sel[i]) begin
               w_active_nxt[i] = 1'b0;
               w_y_nxt[i]      = '0;
            end else if (w_step && r_active[i]) begin
               if (r_y[i] == L_ZB) begin
                  w_active_nxt[i] = 1'b0;
                  w_y_nxt[i]      = '0;
                  w_miss_cnt      = w_miss_cnt + MW'(1);
               end else begin
                  w_y_nxt[i] = r_y[i] + 10'd1;
               end
            end else if (w_spawn_sel[i]) begin
               w_active_nxt[i] = 1'b1;
               w_y_nxt[i]      = '0;
            end
         end
         if (w_spawn_due) begin
            w_spawn_nxt = (|w_free) ? '0 : L_GAP;
         end else if (w_step) begin
            w_spawn_nxt = r_spawn_cnt + SW'(1);
         end
         if (|w_hit_sel) begin
            w_hit_nxt = 1'b1;
            if (r_score != 16'hFFFF) begin
               w_score_nxt = r_score + 16'd1;
`ifdef SPEEDUP_EN
               if (w_score_nxt[2:0] == 3'd0) begin
                  w_div_nxt = (w_shrunk < L_DIV_MIN) ? L_DIV_MIN : w_shrunk;
               end
`endif
            end
         end
         w_miss_sum = MW'(r_misses) + w_miss_cnt;
         if (w_miss_cnt != '0) begin
            w_miss_nxt   = 1'b1;
            w_misses_nxt = (w_miss_sum > MW'(15)) ? 4'hF : w_miss_sum[3:0];
         end
      end

      unique case (r_state)
         S_IDLE:  if (w_go) w_state_nxt = S_PLAY;
         S_PLAY:  if (w_go) w_state_nxt = S_PLAY;
                  else if (w_misses_nxt >= L_MAXM) w_state_nxt = S_OVER;
         S_OVER:  if (w_go) w_state_nxt = S_PLAY;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_start_q    <= 1'b0;
         r_button_q   <= 1'b0;
         r_y          <= '{default: '0};
         r_active     <= '0;
         r_score      <= '0;
         r_misses     <= '0;
         r_step_cnt   <= '0;
         r_spawn_cnt  <= '0;
         r_hit_pulse  <= 1'b0;
         r_miss_pulse <= 1'b0;
`ifdef SPEEDUP_EN
         r_cur_div    <= L_DIV;
`endif
      end else begin
         r_state      <= w_state_nxt;
         r_start_q    <= start;
         r_button_q   <= button;
         r_y          <= w_y_nxt;
         r_active     <= w_active_nxt;
         r_score      <= w_score_nxt;
         r_misses     <= w_misses_nxt;
         r_step_cnt   <= w_step_nxt;
         r_spawn_cnt  <= w_spawn_nxt;
         r_hit_pulse  <= w_hit_nxt;
         r_miss_pulse <= w_miss_nxt;
`ifdef SPEEDUP_EN
         r_cur_div    <= w_div_nxt;
`endif
      end
   end

   for (genvar g = 0; g < NSLOT; g++) begin : g_y
      assign obj_y[10*g +: 10] = r_y[g];
   end

   assign obj_active = r_active;
   assign score      = r_score;
   assign misses     = r_misses;
   assign state      = r_state;
   assign hit_pulse  = r_hit_pulse;
   assign miss_pulse = r_miss_pulse;

endmodule

// File: tb/tb_note_lane_sequencer.sv
// tb/tb_note_lane_sequencer.sv - directed scenarios plus randomized run against a game-rule model
module tb_note_lane_sequencer;
   localparam int NS = 2, SD = 4, SG = 8, ZT = 10, ZB = 14, MM = 3;

   logic clk, reset_n, start, button;
   logic [10*NS-1:0] obj_y;
   logic [NS-1:0]    obj_active;
   logic [15:0]      score;
   logic [3:0]       misses;
   logic [1:0]       state;
   logic             hit_pulse, miss_pulse;

   logic [9:0]  s_y;
   logic        s_act;
   logic [15:0] s_score;
   logic [3:0]  s_misses;
   logic [1:0]  s_state;
   logic        s_hp, s_mp;

   int n_vec, n_err;

   note_lane_sequencer #(.NSLOT(NS), .SPEED_DIV(SD), .SPAWN_GAP(SG), .ZONE_TOP(ZT),
                         .ZONE_BOT(ZB), .MAX_MISS(MM)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .button(button),
      .obj_y(obj_y), .obj_active(obj_active), .score(score), .misses(misses),
      .state(state), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse));

   // single-slot copy: every spawn attempt while the slot is busy is blocked
   note_lane_sequencer #(.NSLOT(1), .SPEED_DIV(SD), .SPAWN_GAP(SG), .ZONE_TOP(ZT),
                         .ZONE_BOT(ZB), .MAX_MISS(MM)) dut1 (
      .clk(clk), .reset_n(reset_n), .start(start), .button(button),
      .obj_y(s_y), .obj_active(s_act), .score(s_score), .misses(s_misses),
      .state(s_state), .hit_pulse(s_hp), .miss_pulse(s_mp));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int m_state, m_score, m_misses, m_tick, m_gap, m_div;
   bit m_act [NS];
   int m_y [NS];
   bit m_hp, m_mp, m_bq, m_sq;

   task automatic model_reset();
      m_state = 0; m_score = 0; m_misses = 0; m_tick = 0; m_gap = 0; m_div = SD;
      m_hp = 0; m_mp = 0; m_bq = 0; m_sq = 0;
      for (int i = 0; i < NS; i++) begin m_act[i] = 0; m_y[i] = 0; end
   endtask

   task automatic model_step(input logic st, input logic btn);
      bit press, go, step;
      bit oact [NS];
      int oy [NS];
      int hit, nmiss, sp;
      press = btn && !m_bq;
      go = st && !m_sq;
      m_bq = btn; m_sq = st;
      m_hp = 0; m_mp = 0;
      if (go) begin
         m_state = 1; m_score = 0; m_misses = 0; m_tick = 0; m_gap = 0; m_div = SD;
         for (int i = 0; i < NS; i++) begin m_act[i] = 0; m_y[i] = 0; end
         return;
      end
      if (m_state != 1) return;
      oact = m_act; oy = m_y;
      m_tick++;
      step = (m_tick >= m_div);
      if (step) m_tick = 0;
      hit = -1;
      if (press)
         for (int i = 0; i < NS; i++)
            if (hit < 0 && oact[i] && oy[i] >= ZT && oy[i] <= ZB) hit = i;
      nmiss = 0;
      for (int i = 0; i < NS; i++) begin
         if (i == hit) begin
            m_act[i] = 0; m_y[i] = 0;
         end else if (step && oact[i]) begin
            if (oy[i] + 1 > ZB) begin m_act[i] = 0; m_y[i] = 0; nmiss++; end
            else m_y[i] = oy[i] + 1;
         end
      end
      if (step) begin
         if (m_gap < SG) m_gap++;
         if (m_gap == SG) begin
            sp = -1;
            for (int i = 0; i < NS; i++) if (sp < 0 && !oact[i]) sp = i;
            if (sp >= 0) begin m_act[sp] = 1; m_y[sp] = 0; m_gap = 0; end
         end
      end
      if (hit >= 0) begin
         m_hp = 1;
         if (m_score < 65535) begin
            m_score++;
`ifdef SPEEDUP_EN
            if (m_score % 8 == 0) m_div = (m_div - m_div / 8 < SD / 4) ? SD / 4 : m_div - m_div / 8;
`endif
         end
      end
      if (nmiss > 0) begin
         m_mp = 1;
         m_misses = (m_misses + nmiss > 15) ? 15 : m_misses + nmiss;
      end
      if (m_misses >= MM) m_state = 2;
   endtask

   task automatic tick(input logic st, input logic btn);
      start = st; button = btn;
      model_step(st, btn);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start = 1'b0; button = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_vec++; if (state !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d exp 0", state); end
      n_vec++; if (obj_active !== '0 || obj_y !== '0) begin n_err++; $display("FAIL reset_slots got act=%b y=%h exp 0", obj_active, obj_y); end
      n_vec++; if (score !== 16'd0 || misses !== 4'd0) begin n_err++; $display("FAIL reset_counts got score=%0d misses=%0d exp 0", score, misses); end
      n_vec++; if (hit_pulse !== 1'b0 || miss_pulse !== 1'b0) begin n_err++; $display("FAIL reset_pulses got %b%b exp 00", hit_pulse, miss_pulse); end
      reset_n = 1'b1;
      repeat (8) tick(0, 0);
      n_vec++; if (state !== 2'd0 || obj_active !== '0) begin n_err++; $display("FAIL idle_hold got state=%0d act=%b exp 0/0", state, obj_active); end
   endtask

   task automatic test_spawn_motion();
      tick(1, 0);
      n_vec++; if (state !== 2'd1) begin n_err++; $display("FAIL go_state got %0d exp 1", state); end
      repeat (31) tick(0, 0);
      n_vec++; if (obj_active !== 2'b00) begin n_err++; $display("FAIL early_spawn got act=%b exp 00", obj_active); end
      tick(0, 0);
      n_vec++; if (obj_active !== 2'b01 || obj_y[9:0] !== 10'd0) begin n_err++; $display("FAIL first_spawn got act=%b y0=%0d exp 01/0", obj_active, obj_y[9:0]); end
      repeat (20) tick(0, 0);
      n_vec++; if (obj_y[9:0] !== 10'd5) begin n_err++; $display("FAIL fall_5 got y0=%0d exp 5", obj_y[9:0]); end
      repeat (12) tick(0, 0);
      n_vec++; if (obj_active !== 2'b11 || obj_y[19:10] !== 10'd0 || obj_y[9:0] !== 10'd8) begin
         n_err++; $display("FAIL second_spawn got act=%b y1=%0d y0=%0d exp 11/0/8", obj_active, obj_y[19:10], obj_y[9:0]);
      end
   endtask

   task automatic test_hit();
      repeat (16) tick(0, 0);
      n_vec++; if (obj_y[9:0] !== 10'd12) begin n_err++; $display("FAIL pre_hit_y got %0d exp 12", obj_y[9:0]); end
      tick(0, 1);
      n_vec++; if (hit_pulse !== 1'b1 || obj_active !== 2'b10 || score !== 16'd1) begin
         n_err++; $display("FAIL hit got pulse=%b act=%b score=%0d exp 1/10/1", hit_pulse, obj_active, score);
      end
      tick(0, 0);
      n_vec++; if (hit_pulse !== 1'b0) begin n_err++; $display("FAIL hit_pulse_width got %b exp 0", hit_pulse); end
      tick(0, 1);
      n_vec++; if (hit_pulse !== 1'b0 || score !== 16'd1) begin n_err++; $display("FAIL empty_press got pulse=%b score=%0d exp 0/1", hit_pulse, score); end
      tick(0, 0);
   endtask

   task automatic test_miss_over();
      int pt[$];
      int pm[$];
      tick(1, 0);
      for (int t = 1; t <= 160; t++) begin
         tick(0, 0);
         if (miss_pulse === 1'b1) begin pt.push_back(t); pm.push_back(int'(misses)); end
         if (t == 64) begin
            n_vec++; if (s_act !== 1'b1 || s_y !== 10'd8) begin n_err++; $display("FAIL blocked_spawn got act=%b y=%0d exp 1/8", s_act, s_y); end
         end
         if (t == 92) begin
            n_vec++; if (s_act !== 1'b0 || s_mp !== 1'b1) begin n_err++; $display("FAIL no_reuse_on_free got act=%b mp=%b exp 0/1", s_act, s_mp); end
         end
         if (t == 96) begin
            n_vec++; if (s_act !== 1'b1 || s_y !== 10'd0) begin n_err++; $display("FAIL retry_spawn got act=%b y=%0d exp 1/0", s_act, s_y); end
         end
      end
      n_vec++; if (pt.size() != 3) begin n_err++; $display("FAIL miss_count got %0d pulses exp 3", pt.size()); end
      else begin
         n_vec++; if (pt[0] != 92 || pt[1] != 124 || pt[2] != 156) begin n_err++; $display("FAIL miss_times got %0d,%0d,%0d exp 92,124,156", pt[0], pt[1], pt[2]); end
         n_vec++; if (pm[0] != 1 || pm[1] != 2 || pm[2] != 3) begin n_err++; $display("FAIL miss_values got %0d,%0d,%0d exp 1,2,3", pm[0], pm[1], pm[2]); end
      end
      n_vec++; if (state !== 2'd2) begin n_err++; $display("FAIL over_state got %0d exp 2", state); end
      repeat (40) tick(0, 1);
      n_vec++; if (obj_active !== 2'b10 || obj_y[19:10] !== 10'd7 || score !== 16'd0 || misses !== 4'd3) begin
         n_err++; $display("FAIL over_freeze got act=%b y1=%0d score=%0d misses=%0d exp 10/7/0/3", obj_active, obj_y[19:10], score, misses);
      end
      tick(0, 0);
   endtask

   task automatic test_hit_on_step();
      tick(1, 0);
      repeat (91) tick(0, 0);
      n_vec++; if (obj_y[9:0] !== 10'd14 || misses !== 4'd0) begin n_err++; $display("FAIL edge_setup got y0=%0d misses=%0d exp 14/0", obj_y[9:0], misses); end
      tick(0, 1);
      n_vec++; if (hit_pulse !== 1'b1 || miss_pulse !== 1'b0 || misses !== 4'd0 || score !== 16'd1) begin
         n_err++; $display("FAIL hit_vs_step got hp=%b mp=%b misses=%0d score=%0d exp 1/0/0/1", hit_pulse, miss_pulse, misses, score);
      end
      n_vec++; if (obj_active !== 2'b10 || obj_y[19:10] !== 10'd7) begin n_err++; $display("FAIL hit_vs_step_slots got act=%b y1=%0d exp 10/7", obj_active, obj_y[19:10]); end
      tick(0, 0);
   endtask

   task automatic test_restart();
      tick(1, 0);
      n_vec++; if (state !== 2'd1 || score !== 16'd0 || obj_active !== '0 || misses !== 4'd0) begin
         n_err++; $display("FAIL restart got state=%0d score=%0d act=%b misses=%0d exp 1/0/00/0", state, score, obj_active, misses);
      end
      tick(0, 0);
   endtask

   task automatic test_async_reset();
      bit in_zone;
      for (int t = 0; t < 1200 && m_score < 5; t++) begin
         in_zone = 0;
         for (int i = 0; i < NS; i++) if (m_act[i] && m_y[i] >= ZT && m_y[i] <= ZB) in_zone = 1;
         if (in_zone && !m_bq) tick(0, 1); else tick(0, 0);
      end
      n_vec++; if (score !== 16'd5 || state !== 2'd1) begin n_err++; $display("FAIL score_5 got score=%0d state=%0d exp 5/1", score, state); end
      button = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      n_vec++; if (state !== 2'd0 || score !== 16'd0 || misses !== 4'd0 || obj_active !== '0 || obj_y !== '0) begin
         n_err++; $display("FAIL async_reset got state=%0d score=%0d misses=%0d act=%b y=%h exp all 0", state, score, misses, obj_active, obj_y);
      end
      @(negedge clk);
      reset_n = 1'b1;
      tick(0, 0);
      n_vec++; if (hit_pulse !== 1'b0 || miss_pulse !== 1'b0 || state !== 2'd0) begin
         n_err++; $display("FAIL reset_release got hp=%b mp=%b state=%0d exp 0/0/0", hit_pulse, miss_pulse, state);
      end
   endtask

   task automatic test_random();
      logic st, btn;
      logic [NS-1:0] e_act;
      logic [10*NS-1:0] e_y, msk;
      int shown = 0;
      for (int c = 0; c < 3000; c++) begin
         st  = (c == 0) || ($urandom_range(0, 399) == 0);
         btn = ($urandom_range(0, 3) == 0) ? ~button : button;
         tick(st, btn);
         e_y = '0; msk = '0;
         for (int i = 0; i < NS; i++) begin
            e_act[i] = m_act[i];
            e_y[10*i +: 10] = 10'(m_y[i]);
            if (m_act[i]) msk[10*i +: 10] = 10'h3FF;
         end
         n_vec++;
         if (state !== m_state[1:0] || obj_active !== e_act || (obj_y & msk) !== e_y ||
             score !== m_score[15:0] || misses !== m_misses[3:0] || hit_pulse !== m_hp || miss_pulse !== m_mp) begin
            n_err++;
            if (shown < 20) begin
               shown++;
               $display("FAIL random cyc=%0d got st=%0d act=%b y=%h sc=%0d mi=%0d hp=%b mp=%b exp st=%0d act=%b y=%h sc=%0d mi=%0d hp=%b mp=%b",
                        c, state, obj_active, obj_y & msk, score, misses, hit_pulse, miss_pulse,
                        m_state, e_act, e_y, m_score, m_misses, m_hp, m_mp);
            end
         end
      end
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      test_reset();
      test_spawn_motion();
      test_hit();
      test_miss_over();
      test_hit_on_step();
      test_restart();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
